// File: rtl/serdes_pkg.sv
// Shared constants, FSM state type and helpers for the serializer/deserializer pair.
package serdes_pkg;

  localparam int DATA_W  = 16;
  localparam int MOD_W   = 4;
  localparam int MIN_LEN = 3;

  typedef enum logic {
    IDLE_S = 1'b0,
    RECV_S = 1'b1
  } state_t;

  // Move the 'count' most recent bits (right-aligned in shreg) to the MSB end.
  function automatic logic [DATA_W-1:0] left_align(input logic [DATA_W-1:0] shreg,
                                                   input logic [MOD_W:0]    count);
    logic [MOD_W:0] sh;
    sh = (MOD_W+1)'(DATA_W) - count;
    return shreg << sh;
  endfunction

endpackage

// File: rtl/deserializer.sv
// Rebuilds MSB-first serial bursts into left-aligned parallel words plus a length code.
module deserializer
  import serdes_pkg::*;
#(
  parameter int MIN_LEN_P = MIN_LEN
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_mod_o,
  output logic              deser_data_val_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam logic [MOD_W:0] CNT_ONE  = (MOD_W+1)'(1);
  localparam logic [MOD_W:0] CNT_LAST = (MOD_W+1)'(DATA_W - 1);
  localparam logic [MOD_W:0] CNT_MIN  = (MOD_W+1)'(MIN_LEN_P);

  state_t            state_q, state_d;
  logic [MOD_W:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MOD_W-1:0]  mod_q, mod_d;
  logic              val_q, val_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    err_d   = 1'b0;
    shifted = {shreg_q[DATA_W-2:0], ser_data_i};

    case (state_q)
      IDLE_S: begin
        // shreg is already clear here, so shifting in gives a fresh word
        if (ser_data_val_i) begin
          shreg_d = shifted;
          cnt_d   = CNT_ONE;
          state_d = RECV_S;
        end
      end
      RECV_S: begin
        if (ser_data_val_i) begin
          if (cnt_q == CNT_LAST) begin
            data_d  = shifted;
            mod_d   = '0;
            val_d   = 1'b1;
            state_d = IDLE_S;
            cnt_d   = '0;
            shreg_d = '0;
          end else begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          if (cnt_q >= CNT_MIN) begin
            data_d = left_align(shreg_q, cnt_q);
            mod_d  = cnt_q[MOD_W-1:0];
            val_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE_S;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      default: begin
        state_d = IDLE_S;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= IDLE_S;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  assign deser_data_o     = data_q;
  assign deser_mod_o      = mod_q;
  assign deser_data_val_o = val_q;
  assign err_o            = err_q;
  assign busy_o           = (state_q == RECV_S);

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench: directed bursts plus random bursts against an event-level reference model.
module tb_deserializer;

  logic        clk = 1'b0;
  logic        srst;
  logic        ser_data;
  logic        ser_val;
  logic [15:0] deser_data;
  logic [3:0]  deser_mod;
  logic        deser_val;
  logic        err;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          kind;   // 1 = word delivered, 0 = short-burst error
    logic [15:0] data;
    logic [3:0]  mod;
    int          stamp;  // index of the clock edge that produced the pulse
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];

  logic [15:0] last_data;
  logic [3:0]  last_mod;

  deserializer dut (
    .clk_i            (clk),
    .srst_i           (srst),
    .ser_data_i       (ser_data),
    .ser_data_val_i   (ser_val),
    .deser_data_o     (deser_data),
    .deser_mod_o      (deser_mod),
    .deser_data_val_o (deser_val),
    .err_o            (err),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: collect every pulse with its edge index.
  always @(negedge clk) begin
    if (!srst && (deser_val || err)) begin
      ev_t e;
      check_eq("val_err_exclusive", {31'b0, deser_val & err}, 32'd0);
      e.kind  = deser_val ? 1 : 0;
      e.data  = deser_data;
      e.mod   = deser_mod;
      e.stamp = cyc;
      got_q.push_back(e);
    end
  end

  // Drive one burst MSB first and record what the reference model expects from it.
  // Called and returns at 1 time unit after a rising edge.
  task automatic send_burst(input logic [15:0] w, input int len, input int gap);
    int  c0;
    int  g;
    ev_t e;
    c0 = cyc;
    g  = (len < 16 && gap < 1) ? 1 : gap;
    for (int i = 0; i < len; i++) begin
      ser_val  = 1'b1;
      ser_data = w[15-i];
      check_eq("busy_in_burst", {31'b0, busy}, {31'b0, (i != 0)});
      @(posedge clk); #1;
    end
    if (len >= 3) begin
      e.kind  = 1;
      e.data  = (w >> (16 - len)) << (16 - len);
      e.mod   = 4'(len % 16);
      last_data = e.data;
      last_mod  = e.mod;
    end else begin
      e.kind = 0;
      e.data = last_data;
      e.mod  = last_mod;
    end
    e.stamp = (len == 16) ? c0 + 16 : c0 + len + 1;
    exp_q.push_back(e);
    for (int i = 0; i < g; i++) begin
      ser_val  = 1'b0;
      ser_data = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic flush_compare(input string tag);
    int n;
    ser_val = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_kind"},  got_q[i].kind,  exp_q[i].kind);
      check_eq({tag, "_data"},  {16'b0, got_q[i].data}, {16'b0, exp_q[i].data});
      check_eq({tag, "_mod"},   {28'b0, got_q[i].mod},  {28'b0, exp_q[i].mod});
      check_eq({tag, "_cycle"}, got_q[i].stamp, exp_q[i].stamp);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] w;
    int          len;
    int          gap;

    srst      = 1'b1;
    ser_val   = 1'b0;
    ser_data  = 1'b0;
    last_data = '0;
    last_mod  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_data", {16'b0, deser_data}, 32'd0);
    check_eq("rst_mod",  {28'b0, deser_mod},  32'd0);
    check_eq("rst_val",  {31'b0, deser_val},  32'd0);
    check_eq("rst_err",  {31'b0, err},        32'd0);
    check_eq("rst_busy", {31'b0, busy},       32'd0);
    srst = 1'b0;
    @(posedge clk); #1;

    send_burst(16'hA5C3, 16, 1);
    check_eq("idle_after_full", {31'b0, busy}, 32'd0);
    flush_compare("full16");

    send_burst(16'hB000, 5, 1);   // bits 1,0,1,1,0
    flush_compare("short5");

    send_burst(16'hC000, 2, 1);   // bits 1,1 -> too short
    flush_compare("short2");

    send_burst(16'h1234, 16, 0);
    send_burst(16'hFFFF, 16, 1);
    flush_compare("b2b32");

    // Asynchronous reset part-way through a burst.
    w = 16'h6D2B;
    for (int i = 0; i < 7; i++) begin
      ser_val  = 1'b1;
      ser_data = w[15-i];
      @(posedge clk); #1;
    end
    check_eq("busy_before_rst", {31'b0, busy}, 32'd1);
    #2 srst = 1'b1;
    #1;
    check_eq("arst_busy", {31'b0, busy},       32'd0);
    check_eq("arst_data", {16'b0, deser_data}, 32'd0);
    check_eq("arst_mod",  {28'b0, deser_mod},  32'd0);
    check_eq("arst_val",  {31'b0, deser_val},  32'd0);
    ser_val   = 1'b0;
    last_data = '0;
    last_mod  = '0;
    @(posedge clk); #1;
    srst = 1'b0;
    flush_compare("after_rst");
    send_burst(16'h8001, 16, 1);
    flush_compare("post_rst");

    // Random bursts of every length, with and without gaps.
    for (int k = 0; k < 60; k++) begin
      w   = 16'($urandom);
      len = $urandom_range(1, 16);
      gap = (len == 16) ? $urandom_range(0, 2) : $urandom_range(1, 3);
      send_burst(w, len, gap);
    end
    flush_compare("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
